// File: rtl/vga_state_snapshot.sv
// Double-buffered game-state registers for the VGA controller, published on the vsync falling edge,
// plus the seconds counter. Define FRAME_COUNTER_EN to build the frame counter.
module vga_state_snapshot #(
  parameter int CLK_HZ = 25000000,
  parameter int TIME_W = 16
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iVS,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              commit,
  output logic              commit_pending,
  output logic [31:0]       block1x,
  output logic [31:0]       block1y,
  output logic [31:0]       block2x,
  output logic [31:0]       block2y,
  output logic [31:0]       block3x,
  output logic [31:0]       block3y,
  output logic [31:0]       block4x,
  output logic [31:0]       block4y,
  output logic [31:0]       score,
  output logic [31:0]       blockType,
  output logic [31:0]       screenMode,
  output logic [TIME_W-1:0] sysTime,
  output logic [15:0]       frame_count
);

  localparam int NREG = 11;
  localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               copy_en;
  logic               vs_prev_q;
  logic               frame_edge;
  logic               clr;
  logic [31:0]        shadow_q [NREG];
  logic [31:0]        active_q [NREG];
  logic [PW-1:0]      presc_q, presc_d;
  logic [TIME_W-1:0]  time_q, time_d;

  assign frame_edge = vs_prev_q & ~iVS;
  assign clr        = wr_en && (wr_addr == 4'hF);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= ST_IDLE;
      vs_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      vs_prev_q <= iVS;
    end
  end

  // A commit arriving on the applying edge keeps the FSM pending for the next frame.
  always_comb begin
    state_d = state_q;
    copy_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_edge) begin
          copy_en = 1'b1;
          if (!commit) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign commit_pending = (state_q == ST_PENDING);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
    end else if (wr_en && (wr_addr < 4'd11)) begin
      shadow_q[wr_addr] <= wr_data;
    end
  end

  // Nonblocking copy takes pre-write shadow contents when a write lands on the same edge.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < NREG; i++) active_q[i] <= '0;
    end else if (copy_en) begin
      for (int i = 0; i < NREG; i++) active_q[i] <= shadow_q[i];
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    time_d  = time_q;
    if (clr) begin
      presc_d = '0;
      time_d  = '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      time_d  = time_q + 1'b1;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      presc_q <= '0;
      time_q  <= '0;
    end else begin
      presc_q <= presc_d;
      time_q  <= time_d;
    end
  end

  assign sysTime    = time_q;
  assign block1x    = active_q[0];
  assign block1y    = active_q[1];
  assign block2x    = active_q[2];
  assign block2y    = active_q[3];
  assign block3x    = active_q[4];
  assign block3y    = active_q[5];
  assign block4x    = active_q[6];
  assign block4y    = active_q[7];
  assign score      = active_q[8];
  assign blockType  = active_q[9];
  assign screenMode = active_q[10];

`ifdef FRAME_COUNTER_EN
  logic [15:0] frame_q;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      frame_q <= '0;
    end else if (frame_edge) begin
      frame_q <= frame_q + 16'd1;
    end
  end

  assign frame_count = frame_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_state_snapshot.sv
// Randomised and directed bench for vga_state_snapshot against a frame-level reference model.
module tb_vga_state_snapshot;
  localparam int CLK_HZ = 10;
  localparam int TIME_W = 4;

  logic              clk;
  logic              rst_n;
  logic              vs;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [31:0]       wr_data;
  logic              commit;
  logic              pending;
  logic [31:0]       b1x, b1y, b2x, b2y, b3x, b3y, b4x, b4y, score_o, btype_o, smode_o;
  logic [TIME_W-1:0] systime_o;
  logic [15:0]       fcount_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_shadow [11];
  logic [31:0] m_active [11];
  logic        m_pend;
  logic        m_vs_prev;
  int          m_cyc;
  int          m_frames;

  vga_state_snapshot #(.CLK_HZ(CLK_HZ), .TIME_W(TIME_W)) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
    .commit_pending(pending),
    .block1x(b1x), .block1y(b1y), .block2x(b2x), .block2y(b2y),
    .block3x(b3x), .block3y(b3y), .block4x(b4x), .block4y(b4y),
    .score(score_o), .blockType(btype_o), .screenMode(smode_o),
    .sysTime(systime_o), .frame_count(fcount_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dut_active(int i);
    case (i)
      0: return b1x;   1: return b1y;   2: return b2x;  3: return b2y;
      4: return b3x;   5: return b3y;   6: return b4x;  7: return b4y;
      8: return score_o; 9: return btype_o; default: return smode_o;
    endcase
  endfunction

  function automatic logic [TIME_W-1:0] m_systime();
    return TIME_W'((m_cyc / CLK_HZ) % (1 << TIME_W));
  endfunction

  function automatic logic [15:0] m_fcount();
`ifdef FRAME_COUNTER_EN
    return 16'(m_frames % 65536);
`else
    return 16'd0;
`endif
  endfunction

  task automatic model_reset();
    foreach (m_shadow[i]) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_pend    = 1'b0;
    m_vs_prev = 1'b1;
    m_cyc     = 0;
    m_frames  = 0;
  endtask

  // Applies one clock's worth of the publishing rules to the inputs seen at that edge.
  task automatic model_update();
    logic fe;
    fe = m_vs_prev && !vs;
    m_vs_prev = vs;
    if (fe) m_frames++;
    if (m_pend && fe) begin
      foreach (m_active[i]) m_active[i] = m_shadow[i];
      m_pend = commit;
    end else if (commit) begin
      m_pend = 1'b1;
    end
    if (wr_en && wr_addr <= 4'd10) m_shadow[wr_addr] = wr_data;
    if (wr_en && wr_addr == 4'hF) m_cyc = 0;
    else m_cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    vs = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (100) tick();
    checks++;
    if (pending !== 1'b0) begin
      failures++; $display("FAIL reset_pending got=%0b exp=0", pending);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (dut_active(i) !== 32'd0) begin
        failures++; $display("FAIL reset_active[%0d] got=%0h exp=0", i, dut_active(i));
      end
    end
    checks++;
    if (systime_o !== m_systime()) begin
      failures++; $display("FAIL reset_systime got=%0d exp=%0d", systime_o, m_systime());
    end
    checks++;
    if (fcount_o !== 16'd0) begin
      failures++; $display("FAIL reset_fcount got=%0d exp=0", fcount_o);
    end
  endtask

  task automatic test_commit_basic();
    write_reg(4'd0, 32'd5);
    write_reg(4'd8, 32'd1200);
    write_reg(4'd10, 32'h2000_0000);
    commit = 1'b1; tick(); commit = 1'b0;
    repeat (5) tick();
    checks++;
    if (b1x !== 32'd0 || score_o !== 32'd0) begin
      failures++; $display("FAIL commit_early b1x=%0d score=%0d exp=0,0", b1x, score_o);
    end
    checks++;
    if (pending !== 1'b1) begin
      failures++; $display("FAIL commit_pending_high got=%0b exp=1", pending);
    end
    vs = 1'b0; tick();
    checks++;
    if (b1x !== 32'd5 || score_o !== 32'd1200 || smode_o !== 32'h2000_0000) begin
      failures++;
      $display("FAIL commit_apply b1x=%0d score=%0d smode=%0h exp=5,1200,20000000", b1x, score_o, smode_o);
    end
    checks++;
    if (pending !== 1'b0) begin
      failures++; $display("FAIL commit_pending_clear got=%0b exp=0", pending);
    end
    repeat (3) tick();
    vs = 1'b1; tick();
  endtask

  task automatic test_no_commit();
    write_reg(4'd3, 32'd7);
    repeat (2) begin
      vs = 1'b0; repeat (3) tick();
      vs = 1'b1; repeat (3) tick();
    end
    checks++;
    if (b2y !== 32'd0 || b2y !== m_active[3]) begin
      failures++; $display("FAIL no_commit_b2y got=%0d exp=0", b2y);
    end
  endtask

  task automatic test_commit_on_edge();
    write_reg(4'd8, 32'd77);
    commit = 1'b1; vs = 1'b0; tick(); commit = 1'b0;
    checks++;
    if (score_o !== 32'd1200 || pending !== 1'b1) begin
      failures++; $display("FAIL edge_commit_skip score=%0d pend=%0b exp=1200,1", score_o, pending);
    end
    vs = 1'b1; repeat (4) tick();
    checks++;
    if (pending !== 1'b1) begin
      failures++; $display("FAIL edge_commit_between pend=%0b exp=1", pending);
    end
    // Second commit coincides with the applying edge and must re-arm.
    write_reg(4'd8, 32'd99);
    commit = 1'b1; vs = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'd3;
    tick();
    idle_inputs();
    checks++;
    if (score_o !== 32'd99 || btype_o !== 32'd0 || pending !== 1'b1) begin
      failures++;
      $display("FAIL edge_commit_rearm score=%0d btype=%0d pend=%0b exp=99,0,1", score_o, btype_o, pending);
    end
    vs = 1'b1; tick(); vs = 1'b0; tick();
    checks++;
    if (btype_o !== 32'd3 || pending !== 1'b0) begin
      failures++; $display("FAIL edge_commit_next btype=%0d pend=%0b exp=3,0", btype_o, pending);
    end
    vs = 1'b1; tick();
  endtask

  task automatic test_seconds();
    do_reset();
    repeat (25) tick();
    checks++;
    if (systime_o !== 4'd2) begin
      failures++; $display("FAIL sec_25 got=%0d exp=2", systime_o);
    end
    write_reg(4'hF, 32'hFFFF_FFFF);
    checks++;
    if (systime_o !== 4'd0) begin
      failures++; $display("FAIL sec_clear got=%0d exp=0", systime_o);
    end
    repeat (9) tick();
    checks++;
    if (systime_o !== 4'd0) begin
      failures++; $display("FAIL sec_before_inc got=%0d exp=0", systime_o);
    end
    tick();
    checks++;
    if (systime_o !== 4'd1) begin
      failures++; $display("FAIL sec_inc got=%0d exp=1", systime_o);
    end
    repeat (9) tick();
    write_reg(4'hF, 32'd0);
    checks++;
    if (systime_o !== 4'd0) begin
      failures++; $display("FAIL sec_clear_priority got=%0d exp=0", systime_o);
    end
    repeat (150) tick();
    checks++;
    if (systime_o !== 4'd15) begin
      failures++; $display("FAIL sec_max got=%0d exp=15", systime_o);
    end
    repeat (10) tick();
    checks++;
    if (systime_o !== 4'd0) begin
      failures++; $display("FAIL sec_wrap got=%0d exp=0", systime_o);
    end
  endtask

  task automatic test_frame_count();
    logic [15:0] exp_fc;
    do_reset();
    repeat (3) begin
      vs = 1'b0; repeat (2) tick();
      vs = 1'b1; repeat (2) tick();
    end
    write_reg(4'hF, 32'd0);
`ifdef FRAME_COUNTER_EN
    exp_fc = 16'd3;
`else
    exp_fc = 16'd0;
`endif
    checks++;
    if (fcount_o !== exp_fc) begin
      failures++; $display("FAIL frame_count got=%0d exp=%0d", fcount_o, exp_fc);
    end
  endtask

  task automatic test_reset_pending();
    write_reg(4'd2, 32'h1234);
    commit = 1'b1; tick(); commit = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pending !== 1'b0 || b2x !== 32'd0) begin
      failures++; $display("FAIL reset_mid_pending pend=%0b b2x=%0h exp=0,0", pending, b2x);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    vs = 1'b0; tick(); vs = 1'b1; tick();
    checks++;
    if (pending !== 1'b0 || b2x !== 32'd0) begin
      failures++; $display("FAIL reset_discard pend=%0b b2x=%0h exp=0,0", pending, b2x);
    end
  endtask

  task automatic test_random();
    int n_err;
    do_reset();
    n_err = 0;
    for (int c = 0; c < 1500; c++) begin
      vs      = ($urandom_range(0, 5) != 0);
      commit  = ($urandom_range(0, 5) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      wr_data = $urandom;
      tick();
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (dut_active(i) !== m_active[i]) begin
          failures++; n_err++;
          if (n_err < 10) $display("FAIL rand_active[%0d] cyc=%0d got=%0h exp=%0h", i, c, dut_active(i), m_active[i]);
        end
      end
      checks++;
      if (pending !== m_pend || systime_o !== m_systime() || fcount_o !== m_fcount()) begin
        failures++; n_err++;
        if (n_err < 10)
          $display("FAIL rand_status cyc=%0d pend=%0b/%0b time=%0d/%0d fc=%0d/%0d", c,
                   pending, m_pend, systime_o, m_systime(), fcount_o, m_fcount());
      end
    end
    idle_inputs();
    vs = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    vs    = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_commit_basic();
    test_no_commit();
    test_commit_on_edge();
    test_reset_pending();
    test_seconds();
    test_frame_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
